cache_ctrl: RTL

- Miss-handling controller that sits directly upstream of the 2-way set-associative cache array.
- Accepts word-level CPU load/store requests and drives the array's enable/cmp/write/valid_in controls plus the tag, index, word and data fields.
- On a miss it sequences victim write-back and block refill over a block-wide memory handshake, then replays the access so it hits.
- One request is in flight at a time; the array supplies victim selection.

---
 rtl/cache_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: miss-handling controller in front of a 2-way set-associative
// cache array. One CPU word request is in flight at a time. A miss writes
// back a dirty victim, refills the block over a block-wide memory handshake,
// then replays the access so that it hits.
// Optional build macro: CACHE_STAT_EN adds hit/miss statistics counters;
// without it hit_cnt and miss_cnt are tied to zero.
module cache_ctrl #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 6,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    input  logic [3:0]                   cpu_byte_w_en,
    output logic                         cpu_ack,
    output logic [31:0]                  cpu_rdata,
    output logic                         c_enable,
    output logic                         c_cmp,
    output logic                         c_write,
    output logic                         c_valid_in,
    output logic [3:0]                   c_byte_w_en,
    output logic [TAG_WIDTH-1:0]         c_tag_in,
    output logic [INDEX_WIDTH-1:0]       c_index,
    output logic [OFFSET_WIDTH-1:0]      c_word_sel,
    output logic [31:0]                  c_data_in,
    output logic [(32<<OFFSET_WIDTH)-1:0] c_data_block_in,
    input  logic                         c_hit,
    input  logic                         c_dirty,
    input  logic                         c_valid_out,
    input  logic [TAG_WIDTH-1:0]         c_tag_out,
    input  logic [31:0]                  c_data_out,
    input  logic [(32<<OFFSET_WIDTH)-1:0] c_data_wb,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [(32<<OFFSET_WIDTH)-1:0] mem_wdata,
    input  logic                         mem_ack,
    input  logic [(32<<OFFSET_WIDTH)-1:0] mem_rdata,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
);

    localparam int BLOCK_W = 32 << OFFSET_WIDTH;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t                  state_reg, state_next;
    logic                    req_we_reg;
    logic [TAG_WIDTH-1:0]    req_tag_reg;
    logic [INDEX_WIDTH-1:0]  req_index_reg;
    logic [OFFSET_WIDTH-1:0] req_word_reg;
    logic [31:0]             req_wdata_reg;
    logic [3:0]              req_be_reg;
    logic [TAG_WIDTH-1:0]    wb_tag_reg;
    logic [BLOCK_W-1:0]      wb_data_reg;
    logic                    wb_cap_reg;
    logic [BLOCK_W-1:0]      refill_data_reg;
    logic [31:0]             rdata_reg;
    logic                    wb_first;
    logic [TAG_WIDTH-1:0]    wb_tag_sel;

    // Byte-offset bits of the CPU address carry no information for word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // The array presents the victim combinationally during the first
    // write-back cycle; forward it so the memory sees a stable address/block
    // from the moment mem_req rises, then hold the captured copy.
    assign wb_first   = (state_reg == WRITEBACK) && !wb_cap_reg;
    assign wb_tag_sel = wb_first ? c_tag_out : wb_tag_reg;
    assign mem_wdata  = wb_first ? c_data_wb : wb_data_reg;
    assign mem_addr   = (state_reg == WRITEBACK)
                      ? {wb_tag_sel, req_index_reg, {(OFFSET_WIDTH+2){1'b0}}}
                      : {req_tag_reg, req_index_reg, {(OFFSET_WIDTH+2){1'b0}}};

    // Array address/data fields always come from the request latch.
    assign c_tag_in        = req_tag_reg;
    assign c_index         = req_index_reg;
    assign c_word_sel      = req_word_reg;
    assign c_data_in       = req_wdata_reg;
    assign c_data_block_in = refill_data_reg;

    // Load data bypasses on the ack cycle and is held afterwards.
    assign cpu_rdata = (cpu_ack && !req_we_reg) ? c_data_out : rdata_reg;

    // State register, request latch, write-back/refill buffers and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            req_we_reg      <= 1'b0;
            req_tag_reg     <= '0;
            req_index_reg   <= '0;
            req_word_reg    <= '0;
            req_wdata_reg   <= '0;
            req_be_reg      <= '0;
            wb_tag_reg      <= '0;
            wb_data_reg     <= '0;
            wb_cap_reg      <= 1'b0;
            refill_data_reg <= '0;
            rdata_reg       <= '0;
        end else begin
            state_reg  <= state_next;
            wb_cap_reg <= (state_reg == WRITEBACK);
            if (state_reg == IDLE && cpu_req) begin
                req_we_reg    <= cpu_we;
                req_tag_reg   <= cpu_addr[31 -: TAG_WIDTH];
                req_index_reg <= cpu_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
                req_word_reg  <= cpu_addr[2 +: OFFSET_WIDTH];
                req_wdata_reg <= cpu_wdata;
                req_be_reg    <= cpu_byte_w_en;
            end
            if (wb_first) begin
                wb_tag_reg  <= c_tag_out;
                wb_data_reg <= c_data_wb;
            end
            if (state_reg == ALLOCATE && mem_ack) begin
                refill_data_reg <= mem_rdata;
            end
            if (state_reg == COMPARE && c_hit && !req_we_reg) begin
                rdata_reg <= c_data_out;
            end
        end
    end

    // Next-state logic and array/memory/CPU control outputs.
    always_comb begin
        state_next  = state_reg;
        c_enable    = 1'b0;
        c_cmp       = 1'b0;
        c_write     = 1'b0;
        c_valid_in  = 1'b0;
        c_byte_w_en = 4'h0;
        cpu_ack     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) state_next = COMPARE;
            end
            COMPARE: begin
                c_enable    = 1'b1;
                c_cmp       = 1'b1;
                c_valid_in  = 1'b1;
                c_write     = req_we_reg;
                c_byte_w_en = req_be_reg;
                if (c_hit) begin
                    cpu_ack    = 1'b1;
                    state_next = IDLE;
                end else if (c_valid_out && c_dirty) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                c_enable = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                if (mem_ack) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req = 1'b1;
                if (mem_ack) state_next = REFILL;
            end
            REFILL: begin
                c_enable    = 1'b1;
                c_write     = 1'b1;
                c_valid_in  = 1'b1;
                c_byte_w_en = 4'hF;
                state_next  = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_STAT_EN
    logic        replay_reg;
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    // Count first-time hits and all misses; the replay after a refill is
    // part of the miss, not a hit of its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_reg   <= 1'b0;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            replay_reg <= (state_reg == REFILL);
            if (state_reg == COMPARE && c_hit && !replay_reg) hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (state_reg == COMPARE && !c_hit) miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule
